// File: rtl/topk_merge_16.sv
// topk_merge_16
//   Streaming top-K accumulator placed after a 16-input bitonic sorter.
//   A frame is one or more 16-element vectors, each sorted descending.
//   The block keeps the K largest values seen so far in the frame, in
//   descending order. It presents that list when the frame's last vector
//   has been merged.
//
// Ports
//   clk_i    : clock
//   rst_i    : asynchronous, active-high reset
//   valid_i  : input vector valid
//   ready_o  : block can accept an input vector (EMPTY or RUN)
//   last_i   : qualifies valid_i; the vector is the last of the frame
//   x_i      : sorted input vector, x_i[0] largest, x_i[15] smallest
//   valid_o  : top-K result valid (HOLD)
//   ready_i  : downstream accepts the result
//   topk_o   : running / final top-K list, topk_o[0] largest
//   count_o  : vectors in the frame, saturating
module topk_merge_16 #(
  parameter int DATAWIDTH = 8,
  parameter int K         = 8,
  parameter int CNTWIDTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic                           last_i,
  input  logic [15:0][DATAWIDTH-1:0]     x_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [K-1:0][DATAWIDTH-1:0]    topk_o,
  output logic [CNTWIDTH-1:0]            count_o
);

  // Ranks in the 2K-entry merged list span 0..2K-1.
  localparam int RANKW = $clog2(2 * K);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    MERGE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                        state_reg;
  state_t                        state_next;
  logic [K-1:0][DATAWIDTH-1:0]   acc_reg;
  logic [K-1:0][DATAWIDTH-1:0]   batch_reg;
  logic [CNTWIDTH-1:0]           cnt_reg;
  logic                          first_reg;
  logic                          last_reg;
  logic                          accept;
  logic [K-1:0][DATAWIDTH-1:0]   merged;
  logic [RANKW-1:0]              a_rank [K];
  logic [RANKW-1:0]              b_rank [K];

  // With a sorted input, x_i[K..15] can never reach the top K. They are
  // folded into a dummy net so that they are visibly consumed.
  logic unused_x;
  assign unused_x = ^x_i;

  // Handshake flags come from the state register only.
  assign ready_o = (state_reg == EMPTY) || (state_reg == RUN);
  assign valid_o = (state_reg == HOLD);
  assign accept  = valid_i && ready_o;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY, RUN: if (accept) state_next = MERGE;
      MERGE:      state_next = last_reg ? HOLD : RUN;
      HOLD:       if (ready_i) state_next = EMPTY;
      default:    state_next = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Merge network: the K largest of acc and batch.
  // acc and batch are each sorted descending. The final position of an
  // element is its own index plus the number of elements in the other
  // list that rank ahead of it. Ties go to acc, so an acc element counts
  // only strictly larger batch elements. A batch element counts acc
  // elements that are greater than or equal to it. The ranks are unique,
  // so output slot i is the OR of every element whose rank is i.
  // ---------------------------------------------------------------------
  always_comb begin
    merged = '0;
    for (int j = 0; j < K; j++) begin
      a_rank[j] = RANKW'(j);
      b_rank[j] = RANKW'(j);
      for (int m = 0; m < K; m++) begin
        if (batch_reg[m] > acc_reg[j]) a_rank[j] = a_rank[j] + 1'b1;
        if (acc_reg[m] >= batch_reg[j]) b_rank[j] = b_rank[j] + 1'b1;
      end
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (a_rank[j] == RANKW'(i)) merged[i] = merged[i] | acc_reg[j];
        if (b_rank[j] == RANKW'(i)) merged[i] = merged[i] | batch_reg[j];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg   <= '0;
      batch_reg <= '0;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      if (accept) begin
        batch_reg <= x_i[K-1:0];
        last_reg  <= last_i;
        first_reg <= (state_reg == EMPTY);
      end
      if (state_reg == MERGE) begin
        if (first_reg) begin
          // The first merge of a frame overwrites the previous result.
          acc_reg <= batch_reg;
          cnt_reg <= CNTWIDTH'(1);
        end else begin
          acc_reg <= merged;
          if (cnt_reg != {CNTWIDTH{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // The outputs always show acc and cnt. They are meaningful only while
  // valid_o is high.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : gen_topk
      assign topk_o[gi] = acc_reg[gi];
    end
  endgenerate

  assign count_o = cnt_reg;

endmodule
